// File: rtl/pattern_sequencer.sv
// pattern_sequencer: playback controller for the eight-instance pattern buffer array.
//
// Walks buffers first_buf..last_buf (index wraps 7 -> 0) field by field. It drives
// one-hot buffer, buffer-view and field pointers. It also arbitrates a single
// write-back requester onto the array's field write port. Every output comes
// straight from a flop.
//
// Optional feature: define SEQ_LOOP_EN to honour the loop input. When loop is set,
// the sequence restarts at first_buf after last_buf and runs until stop.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, stop, pause     playback control (start/stop pulses, pause level)
//   first_buf, last_buf    buffer range of the sequence
//   field_last             last field index per buffer (clamped to buffer_size-1)
//   loop                   repeat the sequence (SEQ_LOOP_EN builds only)
//   wr_req/wr_field/wr_data  write-back request, held until wr_ack
//   bufp, buffer_select    one-hot current buffer (identical)
//   fieldp, fieldp2        one-hot read field pointer (identical copies)
//   fieldwp, field_in, field_write  array write port
//   wr_ack, wr_err         write acknowledge / rejected-write pulses
//   busy, done             running flag, end-of-sequence pulse
module pattern_sequencer #(
    parameter int unsigned BufferSize  = 22,
    parameter int unsigned BufferWidth = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic [2:0]             first_buf,
    input  logic [2:0]             last_buf,
    input  logic [4:0]             field_last,
    input  logic                   loop,
    input  logic                   wr_req,
    input  logic [4:0]             wr_field,
    input  logic [BufferWidth-1:0] wr_data,
    output logic [7:0]             bufp,
    output logic [7:0]             buffer_select,
    output logic [BufferSize-1:0]  fieldp,
    output logic [BufferSize-1:0]  fieldp2,
    output logic [BufferSize-1:0]  fieldwp,
    output logic [BufferWidth-1:0] field_in,
    output logic                   field_write,
    output logic                   wr_ack,
    output logic                   wr_err,
    output logic                   busy,
    output logic                   done
);

    localparam logic [4:0]            FieldCount = 5'(BufferSize);
    localparam logic [4:0]            FieldMax   = 5'(BufferSize - 1);
    localparam logic [BufferSize-1:0] FieldOne   = BufferSize'(1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [2:0] buf_idx_q, buf_idx_d;
    logic [4:0] field_idx_q, field_idx_d;
    logic       stop_pend_q, stop_pend_d;
    logic       done_d;

    logic [7:0]             bufp_q, buffer_select_q;
    logic [BufferSize-1:0]  fieldp_q, fieldp2_q, fieldwp_q;
    logic [BufferWidth-1:0] field_in_q;
    logic                   field_write_q, wr_ack_q, wr_err_q, busy_q, done_q;

    logic       loop_en;
    logic [4:0] field_last_c;
    logic       at_last;
    logic       accept;
    logic       wr_in_range;

`ifdef SEQ_LOOP_EN
    assign loop_en = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_en     = 1'b0;
`endif

    assign field_last_c = (field_last > FieldMax) ? FieldMax : field_last;
    assign at_last      = (field_idx_q == field_last_c);

    // Blocking the advancing last-field cycle makes a write land in the buffer that was
    // current when it was accepted.
    assign accept      = (state_q == StRun) && wr_req && !wr_ack_q && !(!pause && at_last);
    assign wr_in_range = (wr_field < FieldCount);

    always_comb begin
        state_d     = state_q;
        buf_idx_d   = buf_idx_q;
        field_idx_d = field_idx_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    buf_idx_d   = first_buf;
                    field_idx_d = '0;
                    stop_pend_d = 1'b0;
                end
            end
            StRun: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (!pause) begin
                    if (at_last) begin
                        if (stop_pend_q || ((buf_idx_q == last_buf) && !loop_en)) begin
                            // Pointers keep showing the final buffer/field while idle.
                            state_d     = StIdle;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            field_idx_d = '0;
                            buf_idx_d   = (buf_idx_q == last_buf) ? first_buf
                                                                  : buf_idx_q + 3'd1;
                        end
                    end else begin
                        field_idx_d = field_idx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            buf_idx_q       <= '0;
            field_idx_q     <= '0;
            stop_pend_q     <= 1'b0;
            bufp_q          <= 8'b0000_0001;
            buffer_select_q <= 8'b0000_0001;
            fieldp_q        <= FieldOne;
            fieldp2_q       <= FieldOne;
            fieldwp_q       <= '0;
            field_in_q      <= '0;
            field_write_q   <= 1'b0;
            wr_ack_q        <= 1'b0;
            wr_err_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_idx_q       <= buf_idx_d;
            field_idx_q     <= field_idx_d;
            stop_pend_q     <= stop_pend_d;
            // Pointers are decoded from next-state indices so the one-hot fanout is flopped.
            bufp_q          <= 8'b0000_0001 << buf_idx_d;
            buffer_select_q <= 8'b0000_0001 << buf_idx_d;
            fieldp_q        <= FieldOne << field_idx_d;
            fieldp2_q       <= FieldOne << field_idx_d;
            fieldwp_q       <= (accept && wr_in_range) ? (FieldOne << wr_field) : '0;
            if (accept && wr_in_range) begin
                field_in_q <= wr_data;
            end
            field_write_q   <= accept && wr_in_range;
            wr_ack_q        <= accept;
            wr_err_q        <= accept && !wr_in_range;
            busy_q          <= (state_d == StRun);
            done_q          <= done_d;
        end
    end

    assign bufp          = bufp_q;
    assign buffer_select = buffer_select_q;
    assign fieldp        = fieldp_q;
    assign fieldp2       = fieldp2_q;
    assign fieldwp       = fieldwp_q;
    assign field_in      = field_in_q;
    assign field_write   = field_write_q;
    assign wr_ack        = wr_ack_q;
    assign wr_err        = wr_err_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: playback ranges, wrap, clamp, pause, stop,
// write arbitration and asynchronous reset. Outputs are sampled 1 time unit after
// each rising edge.
module tb_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, pause, loop, wr_req;
    logic [2:0]  first_buf, last_buf;
    logic [4:0]  field_last, wr_field;
    logic [7:0]  wr_data;
    logic [7:0]  bufp, buffer_select, field_in;
    logic [21:0] fieldp, fieldp2, fieldwp;
    logic        field_write, wr_ack, wr_err, busy, done;

    int total = 0;
    int bad   = 0;

    pattern_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .pause        (pause),
        .first_buf    (first_buf),
        .last_buf     (last_buf),
        .field_last   (field_last),
        .loop         (loop),
        .wr_req       (wr_req),
        .wr_field     (wr_field),
        .wr_data      (wr_data),
        .bufp         (bufp),
        .buffer_select(buffer_select),
        .fieldp       (fieldp),
        .fieldp2      (fieldp2),
        .fieldwp      (fieldwp),
        .field_in     (field_in),
        .field_write  (field_write),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pointer check for the running state: buffer index b, field index f.
    task automatic check_ptr(input string tag, input int b, input int f);
        logic [7:0]  eb;
        logic [21:0] ef;
        eb = 8'd1 << b;
        ef = 22'd1 << f;
        check({tag, "_bufp"}, {24'd0, bufp}, {24'd0, eb});
        check({tag, "_bsel"}, {24'd0, buffer_select}, {24'd0, eb});
        check({tag, "_fieldp"}, {10'd0, fieldp}, {10'd0, ef});
        check({tag, "_fieldp2"}, {10'd0, fieldp2}, {10'd0, ef});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bufp"}, {24'd0, bufp}, 32'h01);
        check({tag, "_bsel"}, {24'd0, buffer_select}, 32'h01);
        check({tag, "_fieldp"}, {10'd0, fieldp}, 32'h1);
        check({tag, "_fieldp2"}, {10'd0, fieldp2}, 32'h1);
        check({tag, "_fieldwp"}, {10'd0, fieldwp}, 32'h0);
        check({tag, "_field_in"}, {24'd0, field_in}, 32'h0);
        check({tag, "_fwrite"}, {31'd0, field_write}, 32'd0);
        check({tag, "_ack"}, {31'd0, wr_ack}, 32'd0);
        check({tag, "_err"}, {31'd0, wr_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic check_end(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic launch(input logic [2:0] fb, input logic [2:0] lb, input logic [4:0] fl);
        first_buf  = fb;
        last_buf   = lb;
        field_last = fl;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        wr_req = 1'b0; wr_field = '0; wr_data = '0;
        first_buf = '0; last_buf = '0; field_last = '0;
        #23;
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Buffers 2..3, four fields each: 8 RUN cycles then done.
        launch(3'd2, 3'd3, 5'd3);
        check_ptr("r1_b2f0", 2, 0);
        step(); check_ptr("r1_b2f1", 2, 1);
        step(); check_ptr("r1_b2f2", 2, 2);
        step(); check_ptr("r1_b2f3", 2, 3);
        step(); check_ptr("r1_b3f0", 3, 0);
        step(); check_ptr("r1_b3f1", 3, 1);
        step(); check_ptr("r1_b3f2", 3, 2);
        step(); check_ptr("r1_b3f3", 3, 3);
        check("r1_done_early", {31'd0, done}, 32'd0);
        step(); check_end("r1_end");
        step(); check("r1_done_pulse", {31'd0, done}, 32'd0);

        // Range 6..1 wraps through 7 -> 0, one field per buffer.
        launch(3'd6, 3'd1, 5'd0);
        check_ptr("r2_b6", 6, 0);
        step(); check_ptr("r2_b7", 7, 0);
        step(); check_ptr("r2_b0", 0, 0);
        step(); check_ptr("r2_b1", 1, 0);
        step(); check_end("r2_end");
        step();

        // field_last=31 clamps to 21; pause freezes; stop ends after buffer 5.
        launch(3'd5, 3'd6, 5'd31);
        check_ptr("r3_f0", 5, 0);
        for (int i = 0; i < 10; i++) step();
        check_ptr("r3_f10", 5, 10);
        pause = 1'b1;
        step(); step(); step();
        check_ptr("r3_paused", 5, 10);
        pause = 1'b0;
        step(); check_ptr("r3_resume", 5, 11);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_ptr("r3_f12", 5, 12);
        for (int i = 0; i < 9; i++) step();
        check_ptr("r3_f21", 5, 21);
        step(); check_end("r3_stop_end");
        step();

`ifdef SEQ_LOOP_EN
        // Single looping buffer: stays on buffer 5 until stopped.
        loop = 1'b1;
        launch(3'd5, 3'd5, 5'd21);
        for (int i = 0; i < 21; i++) step();
        check_ptr("lp_f21", 5, 21);
        step(); check_ptr("lp_wrap", 5, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_ptr("lp_last", 5, 21);
        step(); check_end("lp_end");
        loop = 1'b0;
        step();
`endif

        // Write arbitration on buffers 1..2, 22 fields each.
        launch(3'd1, 3'd2, 5'd21);
        wr_req = 1'b1; wr_field = 5'd7; wr_data = 8'hA5;
        step();
        wr_req = 1'b0;
        check("w1_ack", {31'd0, wr_ack}, 32'd1);
        check("w1_fwrite", {31'd0, field_write}, 32'd1);
        check("w1_fieldwp", {10'd0, fieldwp}, 32'h80);
        check("w1_field_in", {24'd0, field_in}, 32'hA5);
        check("w1_err", {31'd0, wr_err}, 32'd0);
        step();
        check("w1_ack_pulse", {31'd0, wr_ack}, 32'd0);
        check("w1_fwrite_pulse", {31'd0, field_write}, 32'd0);
        check("w1_fieldwp_clr", {10'd0, fieldwp}, 32'h0);
        check("w1_field_in_hold", {24'd0, field_in}, 32'hA5);
        wr_req = 1'b1; wr_field = 5'd25; wr_data = 8'h3C;
        step();
        wr_req = 1'b0;
        check("w2_ack", {31'd0, wr_ack}, 32'd1);
        check("w2_err", {31'd0, wr_err}, 32'd1);
        check("w2_fwrite", {31'd0, field_write}, 32'd0);
        check("w2_fieldwp", {10'd0, fieldwp}, 32'h0);
        check("w2_field_in", {24'd0, field_in}, 32'hA5);
        step();
        check("w2_err_pulse", {31'd0, wr_err}, 32'd0);
        for (int i = 0; i < 17; i++) step();
        check_ptr("w3_b1f21", 1, 21);
        wr_req = 1'b1; wr_field = 5'd2; wr_data = 8'h5A;
        step();
        check("w3_blocked", {31'd0, wr_ack}, 32'd0);
        check_ptr("w3_b2f0", 2, 0);
        step();
        wr_req = 1'b0;
        check("w3_ack", {31'd0, wr_ack}, 32'd1);
        check("w3_fieldwp", {10'd0, fieldwp}, 32'h4);
        check("w3_field_in", {24'd0, field_in}, 32'h5A);
        check_ptr("w3_b2f1", 2, 1);

        // Asynchronous reset mid-RUN with a request pending.
        wr_req = 1'b1; wr_field = 5'd3; wr_data = 8'hC3;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        wr_req = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        check("arst_idle_busy", {31'd0, busy}, 32'd0);
        check("arst_no_ack", {31'd0, wr_ack}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Playback controller for the eight-instance pattern buffer array. Walks a programmed range of buffers field by field, driving the one-hot buffer, buffer-view and field pointers the array consumes, and arbitrates a single write-back requester onto the array's field write port so updates land in the buffer currently playing. Sits between the control/sequence registers and the buffer array; all outputs are registered so the wide one-hot fanout starts from flops.

## Interface
- buffer_size, 22, fields (bytes) per buffer
- buffer_width, 8, bits per field
- no_bufs, 8, buffer instances; fixed at 8 (3-bit indices)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin playback (IDLE only)
- stop  in  1  pulse; finish current buffer, then return to IDLE
- pause  in  1  level; freeze field/buffer advance while high
- first_buf  in  3  first buffer index of sequence
- last_buf  in  3  last buffer index of sequence
- field_last  in  5  last field index per buffer; values >= buffer_size clamp to buffer_size-1
- loop  in  1  wrap last_buf -> first_buf (only with SEQ_LOOP_EN)
- wr_req  in  1  write request, held until wr_ack
- wr_field  in  5  target field index in current buffer
- wr_data  in  buffer_width  write data
- bufp  out  8  one-hot current buffer
- buffer_select  out  8  one-hot buffer view select
- fieldp, fieldp2  out  buffer_size  one-hot read field pointer (identical copies, split fanout)
- fieldwp  out  buffer_size  one-hot write field pointer
- field_in  out  buffer_width  write data to array
- field_write  out  1  write strobe
- wr_ack  out  1  one-cycle acknowledge
- wr_err  out  1  one-cycle pulse: write rejected (index out of range)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on sequence end

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- IDLE: start=1 -> RUN; next cycle bufp=buffer_select=onehot(first_buf), fieldp=fieldp2=onehot(0). stop/pause ignored.
- RUN, pause=0: field index +1 per cycle. At field index == clamped field_last: field -> 0, buffer index -> next.
- Next buffer: index+1 mod 8 (so last_buf < first_buf wraps through 7->0). If current == last_buf: with loop (SEQ_LOOP_EN) -> first_buf, stay RUN; else -> IDLE, done=1.
- stop in RUN latched in stop_pend; at next end-of-buffer -> IDLE, done=1 regardless of loop. stop_pend cleared on IDLE entry.
- first_buf == last_buf: single buffer, repeated per loop.
- buffer_select always equals bufp; both stay one-hot at all times (never zero, never multi-hot).
- IDLE holds last bufp/buffer_select/fieldp values.
- Write arbitration: wr_req accepted when state==RUN, wr_ack==0 and not (pause==0 and field index == field_last). Accept -> next cycle wr_ack=1; if wr_field < buffer_size: field_write=1, fieldwp=onehot(wr_field), field_in=wr_data; else wr_err=1, field_write=0, fieldwp=0.
- field_write/fieldwp/wr_ack/wr_err are single-cycle; fieldwp=0 when field_write=0. field_in holds last data.
- Write targets the buffer in bufp at the strobe cycle; blocking the last-field cycle guarantees it is the buffer current at acceptance.

## Timing
- Reset values: bufp=buffer_select=8'b00000001, fieldp=fieldp2=1, fieldwp=0, field_in=0, field_write=0, wr_ack=0, wr_err=0, busy=0, done=0.
- start -> busy and first pointers: 1 cycle. Field pointer advances every non-paused RUN cycle.
- Buffer change appears on bufp and buffer_select in the same cycle as fieldp returns to 1.
- done asserted in the cycle busy falls.
- wr_req -> wr_ack: 1 cycle minimum; minimum 2 cycles between acks.
- pause asserted: pointers hold starting next edge; writes accepted in every paused cycle (subject to wr_ack gap).
- rst_n low mid-RUN: immediate return to reset values, pending write discarded.

## Configuration
- SEQ_LOOP_EN defined: loop input honoured; sequence repeats first_buf..last_buf until stop.
- Not defined: loop ignored (treated 0); sequence ends at last_buf, done pulses.

## Test plan
- Reset, first_buf=2, last_buf=3, field_last=3, start -> bufp 00000100 for 4 cycles, fieldp 1,2,4,8, then 00001000, then IDLE with done=1 after 8 RUN cycles.
- first_buf=6, last_buf=1, field_last=0 -> bufp 0x40,0x80,0x01,0x02 on consecutive cycles, then done.
- SEQ_LOOP_EN, loop=1, first=last=5, field_last=21 -> bufp stays 0x20, fieldp wraps 2^21 -> 1; stop mid-buffer -> IDLE exactly after field 21, done=1.
- RUN, wr_req with wr_field=7, wr_data=0xA5 -> next cycle field_write=1, fieldwp=0x80, field_in=0xA5, wr_ack=1; wr_field=25 -> wr_err=1, field_write=0.
- wr_req held during last-field cycle -> no ack that cycle; ack next cycle with bufp already on new buffer.
- pause=1 for 3 cycles mid-buffer -> fieldp frozen; rst_n low during RUN -> all outputs at reset values asynchronously.
